// File: rtl/mage_run_ctrl.sv
// Run controller for one Mage kernel execution: gates each DMA channel's FIFO
// handshake, counts accepted beats down to zero and reports completion, or
// flags an error on an empty start or a stalled PEA (watchdog).
module mage_run_ctrl #(
  parameter int unsigned N_DMA_CH = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TO_W     = 20
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic                      status_clr_i,
  input  logic [N_DMA_CH-1:0]       ch_en_i,
  input  logic [N_DMA_CH*CNT_W-1:0] ch_len_i,
  input  logic [N_DMA_CH-1:0]       beat_i,
  output logic [N_DMA_CH-1:0]       gate_o,
  output logic [N_DMA_CH-1:0]       ch_done_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      irq_o
);

  typedef enum logic [2:0] {StIdle, StArm, StRun, StDone, StErr} state_e;

  state_e                           state_q;
  logic [N_DMA_CH-1:0]              en_q;
  logic [N_DMA_CH-1:0][CNT_W-1:0]   rem_q;
  logic [TO_W-1:0]                  wd_q;
  logic                             irq_q;

  logic [N_DMA_CH-1:0]              left;
  logic [N_DMA_CH-1:0]              gate;
  logic [N_DMA_CH-1:0]              accept;
  logic                             any_accept;
  logic                             all_zero;
  logic                             wd_hit;

  // Decode gating, accepted beats and run-end conditions from registered state.
  always_comb begin
    left = '0;
    for (int i = 0; i < int'(N_DMA_CH); i++) begin
      left[i] = (rem_q[i] != '0);
    end
    gate       = (state_q == StRun) ? (en_q & left) : '0;
    accept     = beat_i & gate;
    any_accept = |accept;
    all_zero   = ((en_q & left) == '0);
    // Next idle increment lands on all-ones.
    wd_hit     = !any_accept && (wd_q == ~TO_W'(1));
  end

  // Run sequencer: state, latched enables, beat counters, watchdog and irq pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      en_q    <= '0;
      rem_q   <= '0;
      wd_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if ((state_q == StDone) && status_clr_i) begin
            state_q <= StIdle;
          end else if (start_i) begin
            en_q <= ch_en_i;
            if (|ch_en_i) begin
              state_q <= StArm;
            end else begin
              state_q <= StErr;
              irq_q   <= 1'b1;
            end
          end
        end
        StArm: begin
          for (int i = 0; i < int'(N_DMA_CH); i++) begin
            rem_q[i] <= en_q[i] ? ch_len_i[i*CNT_W +: CNT_W] : '0;
          end
          wd_q    <= '0;
          state_q <= abort_i ? StIdle : StRun;
        end
        StRun: begin
          for (int i = 0; i < int'(N_DMA_CH); i++) begin
            // Gate is only high while rem is non-zero, so this never wraps.
            if (accept[i]) rem_q[i] <= rem_q[i] - CNT_W'(1);
          end
          wd_q <= any_accept ? '0 : wd_q + TO_W'(1);
          if (abort_i) begin
            state_q <= StIdle;
          end else if (all_zero) begin
            state_q <= StDone;
            irq_q   <= 1'b1;
          end else if (wd_hit) begin
            state_q <= StErr;
            irq_q   <= 1'b1;
          end
        end
        StErr: begin
          if (status_clr_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Status outputs decoded from registers only.
  always_comb begin
    gate_o    = gate;
    ch_done_o = (state_q inside {StRun, StDone, StErr}) ? (en_q & ~left) : '0;
    busy_o    = (state_q == StArm) || (state_q == StRun);
    done_o    = (state_q == StDone);
    err_o     = (state_q == StErr);
    irq_o     = irq_q;
  end

endmodule

// File: tb/tb_mage_run_ctrl.sv
// Bench for mage_run_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_mage_run_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned TW = 4;
  // Consecutive beatless RUN cycles that trip the watchdog.
  localparam int WD_LIMIT = (1 << TW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;
  localparam int M_ERR  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          status_clr;
  logic [N-1:0]  ch_en;
  logic [N*CW-1:0] ch_len;
  logic [N-1:0]  beat;
  logic [N-1:0]  gate_o;
  logic [N-1:0]  ch_done_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic          irq_o;

  always #5 clk = ~clk;

  mage_run_ctrl #(
    .N_DMA_CH(N),
    .CNT_W   (CW),
    .TO_W    (TW)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .status_clr_i(status_clr),
    .ch_en_i     (ch_en),
    .ch_len_i    (ch_len),
    .beat_i      (beat),
    .gate_o      (gate_o),
    .ch_done_o   (ch_done_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .irq_o       (irq_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Behavioural model: run phase, enabled set, beats still owed per channel.
  int           ph;
  logic [N-1:0] m_en;
  int           m_left [N];
  int           m_quiet;
  logic         m_irq;

  // Per-scenario observations.
  int acc_cnt [N];
  int gate_hi [N];
  int irq_cnt, irq_at, last_acc, first_gate, busy_cnt, partial_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    ph      = M_IDLE;
    m_en    = '0;
    m_quiet = 0;
    m_irq   = 1'b0;
    for (int i = 0; i < int'(N); i++) m_left[i] = 0;
  endtask

  function automatic int len_of(input int i);
    return int'(ch_len[i*CW +: CW]);
  endfunction

  function automatic logic [N-1:0] exp_gate();
    logic [N-1:0] g = '0;
    for (int i = 0; i < int'(N); i++) g[i] = (ph == M_RUN) && m_en[i] && (m_left[i] > 0);
    return g;
  endfunction

  function automatic logic [N-1:0] exp_ch_done();
    logic [N-1:0] d = '0;
    for (int i = 0; i < int'(N); i++)
      d[i] = (ph == M_RUN || ph == M_DONE || ph == M_ERR) && m_en[i] && (m_left[i] == 0);
    return d;
  endfunction

  // Advance the model across one clock edge using the inputs applied at that edge.
  task automatic model_step();
    logic [N-1:0] acc;
    bit           owed;
    m_irq = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (ph)
      M_IDLE, M_DONE: begin
        if (ph == M_DONE && status_clr) ph = M_IDLE;
        else if (start) begin
          m_en = ch_en;
          if (ch_en != '0) ph = M_ARM;
          else begin
            ph    = M_ERR;
            m_irq = 1'b1;
          end
        end
      end
      M_ARM: begin
        for (int i = 0; i < int'(N); i++) m_left[i] = m_en[i] ? len_of(i) : 0;
        m_quiet = 0;
        ph = abort ? M_IDLE : M_RUN;
      end
      M_RUN: begin
        owed = 1'b0;
        for (int i = 0; i < int'(N); i++) if (m_en[i] && m_left[i] > 0) owed = 1'b1;
        acc = beat & exp_gate();
        for (int i = 0; i < int'(N); i++) if (acc[i]) m_left[i] = m_left[i] - 1;
        m_quiet = (acc != '0) ? 0 : m_quiet + 1;
        if (abort) ph = M_IDLE;
        else if (!owed) begin
          ph    = M_DONE;
          m_irq = 1'b1;
        end else if (m_quiet == WD_LIMIT) begin
          ph    = M_ERR;
          m_irq = 1'b1;
        end
      end
      M_ERR: if (status_clr) ph = M_IDLE;
      default: ph = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    check("gate_o",    32'(gate_o),    32'(exp_gate()));
    check("ch_done_o", 32'(ch_done_o), 32'(exp_ch_done()));
    check("busy_o",    32'(busy_o),    32'(ph == M_ARM || ph == M_RUN));
    check("done_o",    32'(done_o),    32'(ph == M_DONE));
    check("err_o",     32'(err_o),     32'(ph == M_ERR));
    check("irq_o",     32'(irq_o),     32'(m_irq));
  endtask

  task automatic clear_stats();
    for (int i = 0; i < int'(N); i++) begin
      acc_cnt[i] = 0;
      gate_hi[i] = 0;
    end
    irq_cnt = 0; irq_at = -1; last_acc = -1; first_gate = -1; busy_cnt = 0; partial_cnt = 0;
  endtask

  // One clock: step the model at the edge, then sample and compare 1 time unit later.
  task automatic tick();
    logic [N-1:0] pre_acc;
    pre_acc = gate_o & beat;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    for (int i = 0; i < int'(N); i++) begin
      if (pre_acc[i]) begin
        acc_cnt[i]++;
        last_acc = cyc;
      end
      if (gate_o[i]) gate_hi[i]++;
    end
    if (irq_o) begin
      irq_cnt++;
      irq_at = cyc;
    end
    if (gate_o != '0 && first_gate < 0) first_gate = cyc;
    if (busy_o) busy_cnt++;
    if (ch_done_o == 4'b0001) partial_cnt++;
    compare_all();
  endtask

  task automatic set_len(input int l0, input int l1, input int l2, input int l3);
    ch_len = {CW'(l3), CW'(l2), CW'(l1), CW'(l0)};
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
  endtask

  // Drive beats (alternating masks by cycle parity) until the run leaves ARM/RUN.
  task automatic run_to_end(input logic [N-1:0] even, input logic [N-1:0] odd,
                            input int max, input string name);
    int n = 0;
    while (n < max) begin
      beat = (cyc % 2 == 1) ? odd : even;
      tick();
      n++;
      if (!busy_o) break;
    end
    beat = '0;
    check({name, " run ended within bound"}, 32'(busy_o), 32'(0));
  endtask

  initial begin
    int start_edge;
    int dens;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; status_clr = 1'b0;
    ch_en = '0; ch_len = '0; beat = '0;
    model_reset();
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 32'({gate_o, ch_done_o, busy_o, done_o, err_o, irq_o}), 32'(0));
    compare_all();
    rst_n = 1'b1;
    tick();

    // Single channel, three back-to-back beats.
    ch_en = 4'b0001; set_len(3, 0, 0, 0); clear_stats();
    pulse_start();
    start_edge = cyc;
    run_to_end(4'b0001, 4'b0001, 40, "single");
    check("single gate cycles", 32'(gate_hi[0]), 32'(3));
    check("single beats", 32'(acc_cnt[0]), 32'(3));
    check("single irq count", 32'(irq_cnt), 32'(1));
    check("single irq after last beat", 32'(irq_at - last_acc), 32'(1));
    check("single gate after start", 32'(first_gate - start_edge), 32'(1));
    check("single done", 32'(done_o), 32'(1));
    check("single ch_done", 32'(ch_done_o), 32'(4'b0001));
    pulse_clr();
    check("single cleared", 32'(done_o), 32'(0));

    // Mixed channels; ch1 beats must be ignored.
    ch_en = 4'b0101; set_len(2, 7, 5, 0); clear_stats();
    pulse_start();
    run_to_end(4'b0111, 4'b0011, 60, "mixed");
    check("mixed ch0 beats", 32'(acc_cnt[0]), 32'(2));
    check("mixed ch1 beats", 32'(acc_cnt[1]), 32'(0));
    check("mixed ch2 beats", 32'(acc_cnt[2]), 32'(5));
    check("mixed ch0 done early", 32'(partial_cnt > 0), 32'(1));
    check("mixed done", 32'(done_o), 32'(1));
    check("mixed ch_done", 32'(ch_done_o), 32'(4'b0101));
    // Restart straight from DONE.
    ch_en = 4'b0001; set_len(1, 0, 0, 0); clear_stats();
    pulse_start();
    check("restart done cleared", 32'({busy_o, done_o}), 32'(2'b10));
    run_to_end(4'b0001, 4'b0001, 20, "restart");
    check("restart done", 32'(done_o), 32'(1));
    pulse_clr();

    // Zero-length enabled channel completes with no gate pulse.
    ch_en = 4'b0010; set_len(4, 0, 4, 4); clear_stats();
    pulse_start();
    run_to_end(4'b1111, 4'b1111, 10, "zero");
    check("zero gate cycles", 32'(gate_hi[0] + gate_hi[1] + gate_hi[2] + gate_hi[3]), 32'(0));
    check("zero busy cycles", 32'(busy_cnt), 32'(2));
    check("zero done", 32'({done_o, irq_cnt[0]}), 32'(2'b11));
    pulse_clr();

    // Empty start goes straight to ERR; further starts are ignored until cleared.
    ch_en = 4'b0000; clear_stats();
    pulse_start();
    check("empty err irq", 32'({err_o, irq_o}), 32'(2'b11));
    ch_en = 4'b0001;
    pulse_start();
    check("empty start ignored", 32'({err_o, busy_o, irq_o}), 32'(3'b100));
    pulse_clr();
    check("empty cleared", 32'(err_o), 32'(0));

    // Abort after 1 of 4 beats.
    ch_en = 4'b0001; set_len(4, 0, 0, 0); clear_stats();
    pulse_start();
    tick();
    beat = 4'b0001; tick();
    beat = '0; abort = 1'b1; tick(); abort = 1'b0;
    check("abort gate busy", 32'({gate_o, busy_o}), 32'(0));
    repeat (3) tick();
    check("abort beats", 32'(acc_cnt[0]), 32'(1));
    check("abort no irq", 32'({irq_cnt[0], done_o, err_o}), 32'(0));

    // Abort together with the final beat.
    set_len(2, 0, 0, 0); clear_stats();
    pulse_start();
    tick();
    beat = 4'b0001; tick();
    abort = 1'b1; tick(); abort = 1'b0; beat = '0;
    check("abort last busy", 32'({gate_o, busy_o}), 32'(0));
    repeat (3) tick();
    check("abort last beats", 32'(acc_cnt[0]), 32'(2));
    check("abort last no irq", 32'({irq_cnt[0], done_o}), 32'(0));

    // Watchdog: no beats at all.
    set_len(2, 0, 0, 0); clear_stats();
    pulse_start();
    run_to_end(4'b0000, 4'b0000, 40, "watchdog");
    check("watchdog run cycles", 32'(gate_hi[0]), 32'(15));
    check("watchdog err", 32'({err_o, done_o}), 32'(2'b10));
    check("watchdog irq count", 32'(irq_cnt), 32'(1));
    pulse_clr();
    check("watchdog cleared", 32'({err_o, busy_o}), 32'(0));

    // Asynchronous reset mid-run, then a full reload.
    set_len(100, 0, 0, 0); clear_stats();
    pulse_start();
    tick();
    beat = 4'b0001;
    for (int k = 0; k < 10; k++) tick();
    check("pre-reset beats", 32'(acc_cnt[0]), 32'(10));
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async reset outputs", 32'({gate_o, ch_done_o, busy_o, done_o, err_o, irq_o}), 32'(0));
    beat = '0;
    tick();
    rst_n = 1'b1;
    clear_stats();
    pulse_start();
    run_to_end(4'b0001, 4'b0001, 200, "reload");
    check("reload beats", 32'(acc_cnt[0]), 32'(100));
    check("reload gate cycles", 32'(gate_hi[0]), 32'(100));
    check("reload done", 32'(done_o), 32'(1));
    pulse_clr();

    // Randomized traffic against the model.
    dens = 1;
    for (int k = 0; k < 3000; k++) begin
      if (k % 150 == 0) begin
        case ($urandom_range(0, 3))
          0: dens = 0;
          1: dens = 1;
          2: dens = 4;
          default: dens = 25;
        endcase
      end
      start      = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 79) == 0);
      status_clr = ($urandom_range(0, 9) == 0);
      rst_n      = ($urandom_range(0, 799) != 0);
      ch_en      = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      for (int i = 0; i < int'(N); i++) begin
        ch_len[i*CW +: CW] = CW'($urandom_range(0, 6));
        beat[i] = ($urandom_range(0, dens) == 0);
      end
      tick();
    end
    start = 1'b0; abort = 1'b0; status_clr = 1'b0; rst_n = 1'b1; beat = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global time bound reached at cycle %0d", cyc);
    $fatal(1, "time bound");
  end

endmodule
